// File: rtl/fsx_timing_mixer.sv
// fsx_timing_mixer
//   Video timing generator plus N-layer pixel compositor.
//   The raw timing (counters, display enable, active coordinates) drives the
//   layer renderers.  Their colours arrive LAYER_LAT clocks later.  This block
//   resolves priority/transparency and emits sync, DE and RGB332 aligned to
//   the raw timing plus LAYER_LAT+1 clocks.
//
// Ports
//   vga_clk       pixel clock
//   reset         synchronous, active-high reset
//   backdrop      RGB332 shown when no layer pixel is opaque
//   layer_rgb     RGB332 per layer, layer i at [8i+7:8i]
//   layer_valid   per-layer opaque flag
//   layer_behind  per-layer "draw behind layer 0" flag (bit 0 unused)
//   h_count       raw line position including blanking
//   v_count       raw frame position in lines
//   o_de          raw display enable
//   o_h, o_v      raw active x/y, 0 outside the active area
//   vid_hs/vs/de  aligned sync and display enable
//   vid_rgb       aligned RGB332, 0 while vid_de is low
//   crt_sync      composite sync for the CRT pin
//   frame_irq     high for the first IRQ_LEN clocks of every frame
//   frame_count   completed-frame counter (wraps at 2^16)
//
// Handshake: none.  Every output is either combinational from the counters
// (raw group) or registered (vid_* group); there is no valid/ready flow.
module fsx_timing_mixer #(
   parameter int H_RES     = 320,
   parameter int V_RES     = 240,
   parameter int H_FP      = 24,
   parameter int H_SYNC    = 32,
   parameter int H_BP      = 46,
   parameter int V_FP      = 3,
   parameter int V_SYNC    = 5,
   parameter int V_BP      = 14,
   parameter int H_POL     = 0,
   parameter int V_POL     = 0,
   parameter int N_LAYERS  = 2,
   parameter int LAYER_LAT = 2,
   parameter int IRQ_LEN   = 8
) (
   input  logic                    vga_clk,
   input  logic                    reset,
   input  logic [7:0]              backdrop,
   input  logic [8*N_LAYERS-1:0]   layer_rgb,
   input  logic [N_LAYERS-1:0]     layer_valid,
   input  logic [N_LAYERS-1:0]     layer_behind,
   output logic [9:0]              h_count,
   output logic [8:0]              v_count,
   output logic                    o_de,
   output logic [9:0]              o_h,
   output logic [8:0]              o_v,
   output logic                    vid_hs,
   output logic                    vid_vs,
   output logic                    vid_de,
   output logic [7:0]              vid_rgb,
   output logic                    crt_sync,
   output logic                    frame_irq,
   output logic [15:0]             frame_count
);

   // Timing landmarks.  Each region is the half-open interval (STA, END].
   localparam int HS_STA = H_FP - 1;
   localparam int HS_END = HS_STA + H_SYNC;
   localparam int HA_STA = HS_END + H_BP;
   localparam int HA_END = HA_STA + H_RES;
   localparam int VS_STA = V_FP - 1;
   localparam int VS_END = VS_STA + V_SYNC;
   localparam int VA_STA = VS_END + V_BP;
   localparam int VA_END = VA_STA + V_RES;

   localparam logic [9:0]  HS_STA_C = 10'(HS_STA);
   localparam logic [9:0]  HS_END_C = 10'(HS_END);
   localparam logic [9:0]  HA_STA_C = 10'(HA_STA);
   localparam logic [9:0]  HA_END_C = 10'(HA_END);
   localparam logic [9:0]  LINE_C   = 10'(HA_END);
   localparam logic [9:0]  H_ORG_C  = 10'(HA_STA + 1);
   localparam logic [8:0]  VS_STA_C = 9'(VS_STA);
   localparam logic [8:0]  VS_END_C = 9'(VS_END);
   localparam logic [8:0]  VA_STA_C = 9'(VA_STA);
   localparam logic [8:0]  VA_END_C = 9'(VA_END);
   localparam logic [8:0]  FRAME_C  = 9'(VA_END);
   localparam logic [8:0]  V_ORG_C  = 9'(VA_STA + 1);
   localparam logic [10:0] IRQ_C    = 11'(IRQ_LEN);

   // Sync levels are carried internally as "active" flags and only mapped to
   // pin polarity at the output, so every pipeline stage clears to 0.
   localparam logic H_ACT = (H_POL != 0);
   localparam logic V_ACT = (V_POL != 0);

   // Layer 0 is the background and never takes part in the behind test.
   localparam logic [N_LAYERS-1:0] FG_MASK = {{(N_LAYERS-1){1'b1}}, 1'b0};

   // ---------------------------------------------------------------- counters
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_count     <= '0;
         v_count     <= '0;
         frame_count <= '0;
      end else if (h_count == LINE_C) begin
         h_count <= '0;
         if (v_count == FRAME_C) begin
            v_count     <= '0;
            frame_count <= frame_count + 16'd1;
         end else begin
            v_count <= v_count + 9'd1;
         end
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   // ------------------------------------------------------------ raw timing
   logic raw_hs_act;
   logic raw_vs_act;
   logic h_active;
   logic v_active;

   assign raw_hs_act = (h_count > HS_STA_C) && (h_count <= HS_END_C);
   assign raw_vs_act = (v_count > VS_STA_C) && (v_count <= VS_END_C);
   assign h_active   = (h_count > HA_STA_C) && (h_count <= HA_END_C);
   assign v_active   = (v_count > VA_STA_C) && (v_count <= VA_END_C);
   assign o_de       = h_active && v_active;
   assign o_h        = o_de ? (h_count - H_ORG_C) : '0;
   assign o_v        = o_de ? (v_count - V_ORG_C) : '0;
   assign frame_irq  = (v_count == '0) && ({1'b0, h_count} < IRQ_C);

   // ------------------------------------------- delay to match the renderers
   // d_* is the raw timing as seen by the layer colours (LAYER_LAT clocks old).
   logic d_hs;
   logic d_vs;
   logic d_de;

   if (LAYER_LAT == 0) begin : g_no_dly
      assign d_hs = raw_hs_act;
      assign d_vs = raw_vs_act;
      assign d_de = o_de;
   end else begin : g_dly
      logic [2:0] tim_sr [LAYER_LAT];

      always_ff @(posedge vga_clk) begin
         if (reset) begin
            for (int k = 0; k < LAYER_LAT; k++) tim_sr[k] <= 3'b000;
         end else begin
            tim_sr[0] <= {raw_hs_act, raw_vs_act, o_de};
            for (int k = 1; k < LAYER_LAT; k++) tim_sr[k] <= tim_sr[k-1];
         end
      end

      assign {d_hs, d_vs, d_de} = tim_sr[LAYER_LAT-1];
   end

   // ------------------------------------------------------------- compositor
   // Later assignments override earlier ones, so the passes run from lowest
   // priority to highest and each foreground loop counts downwards so the
   // lowest-index match is the one that sticks.
   logic [N_LAYERS-1:0] fg_front;
   logic [N_LAYERS-1:0] fg_back;
   logic [7:0]          mix_rgb;

   assign fg_front = layer_valid & ~layer_behind & FG_MASK;
   assign fg_back  = layer_valid &  layer_behind & FG_MASK;

   always_comb begin
      mix_rgb = backdrop;
      for (int i = N_LAYERS - 1; i >= 1; i--) begin
         if (fg_back[i]) mix_rgb = layer_rgb[8*i +: 8];
      end
      if (layer_valid[0]) mix_rgb = layer_rgb[7:0];
      for (int i = N_LAYERS - 1; i >= 1; i--) begin
         if (fg_front[i]) mix_rgb = layer_rgb[8*i +: 8];
      end
   end

   // --------------------------------------------------------- output stage
   logic hs_q;
   logic vs_q;
   logic de_q;
   logic [7:0] rgb_q;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
         de_q  <= 1'b0;
         rgb_q <= 8'h00;
      end else begin
         hs_q  <= d_hs;
         vs_q  <= d_vs;
         de_q  <= d_de;
         rgb_q <= d_de ? mix_rgb : 8'h00;
      end
   end

   assign vid_hs   = ~(hs_q ^ H_ACT);
   assign vid_vs   = ~(vs_q ^ V_ACT);
   assign vid_de   = de_q;
   assign vid_rgb  = rgb_q;
   assign crt_sync = ~(vid_hs ^ vid_vs);

endmodule

// File: tb/tb_fsx_timing_mixer.sv
// Directed bench for fsx_timing_mixer.
//   dut_a: default parameters (320x240, 2 layers, LAYER_LAT=2).
//   dut_b: tiny raster (14 x 7 = 98 clocks/frame), 4 layers, LAYER_LAT=1,
//          positive hsync, IRQ_LEN=1, so frame wraps happen quickly.
// Both share clock and reset; cyc counts clocks since the last reset release
// (cyc=0 is the first state after release, h_count=0 v_count=0).
module tb_fsx_timing_mixer;

   logic        vga_clk;
   logic        reset;

   logic [7:0]  a_backdrop;
   logic [15:0] a_layer_rgb;
   logic [1:0]  a_layer_valid;
   logic [1:0]  a_layer_behind;
   logic [9:0]  a_h_count;
   logic [8:0]  a_v_count;
   logic        a_o_de;
   logic [9:0]  a_o_h;
   logic [8:0]  a_o_v;
   logic        a_vid_hs, a_vid_vs, a_vid_de;
   logic [7:0]  a_vid_rgb;
   logic        a_crt_sync, a_frame_irq;
   logic [15:0] a_frame_count;

   logic [7:0]  b_backdrop;
   logic [31:0] b_layer_rgb;
   logic [3:0]  b_layer_valid;
   logic [3:0]  b_layer_behind;
   logic [9:0]  b_h_count;
   logic [8:0]  b_v_count;
   logic        b_o_de;
   logic [9:0]  b_o_h;
   logic [8:0]  b_o_v;
   logic        b_vid_hs, b_vid_vs, b_vid_de;
   logic [7:0]  b_vid_rgb;
   logic        b_crt_sync, b_frame_irq;
   logic [15:0] b_frame_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   fsx_timing_mixer dut_a (
      .vga_clk(vga_clk), .reset(reset),
      .backdrop(a_backdrop), .layer_rgb(a_layer_rgb),
      .layer_valid(a_layer_valid), .layer_behind(a_layer_behind),
      .h_count(a_h_count), .v_count(a_v_count), .o_de(a_o_de),
      .o_h(a_o_h), .o_v(a_o_v), .vid_hs(a_vid_hs), .vid_vs(a_vid_vs),
      .vid_de(a_vid_de), .vid_rgb(a_vid_rgb), .crt_sync(a_crt_sync),
      .frame_irq(a_frame_irq), .frame_count(a_frame_count)
   );

   fsx_timing_mixer #(
      .H_RES(8), .V_RES(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(0),
      .N_LAYERS(4), .LAYER_LAT(1), .IRQ_LEN(1)
   ) dut_b (
      .vga_clk(vga_clk), .reset(reset),
      .backdrop(b_backdrop), .layer_rgb(b_layer_rgb),
      .layer_valid(b_layer_valid), .layer_behind(b_layer_behind),
      .h_count(b_h_count), .v_count(b_v_count), .o_de(b_o_de),
      .o_h(b_o_h), .o_v(b_o_v), .vid_hs(b_vid_hs), .vid_vs(b_vid_vs),
      .vid_de(b_vid_de), .vid_rgb(b_vid_rgb), .crt_sync(b_crt_sync),
      .frame_irq(b_frame_irq), .frame_count(b_frame_count)
   );

   // clock
   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // driver tasks
   task automatic tick();
      @(posedge vga_clk);
      #1;
      cyc++;
   endtask

   task automatic advance_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      reset          = 1'b1;
      a_backdrop     = 8'h00;
      a_layer_rgb    = '0;
      a_layer_valid  = '0;
      a_layer_behind = '0;
      b_backdrop     = 8'h00;
      b_layer_rgb    = '0;
      b_layer_valid  = '0;
      b_layer_behind = '0;
      repeat (3) @(posedge vga_clk);
      #1;
      reset = 1'b0;
      cyc   = 0;

      // reset state
      chk("a_h0", a_h_count, 0);
      chk("a_v0", a_v_count, 0);
      chk("a_fc0", a_frame_count, 0);
      chk("a_vde0", a_vid_de, 0);
      chk("a_rgb0", a_vid_rgb, 0);
      chk("a_hs0", a_vid_hs, 1);
      chk("a_vs0", a_vid_vs, 1);
      chk("a_de0", a_o_de, 0);
      chk("a_irq0", a_frame_irq, 1);
      chk("b_hs0", b_vid_hs, 0);
      chk("b_crt0", b_crt_sync, 0);
      chk("b_irq0", b_frame_irq, 1);

      advance_to(1);   chk("b_irq1", b_frame_irq, 0);
      advance_to(4);   chk("b_hs4", b_vid_hs, 1);
                       chk("b_crt4", b_crt_sync, 1);
      advance_to(5);   chk("b_hs5", b_vid_hs, 1);
      advance_to(6);   chk("b_hs6", b_vid_hs, 0);
      advance_to(7);   chk("a_irq7", a_frame_irq, 1);
      advance_to(8);   chk("a_irq8", a_frame_irq, 0);
      advance_to(26);  chk("a_hs26", a_vid_hs, 1);
      advance_to(27);  chk("a_hs27", a_vid_hs, 0);

      // dut_b first active pixel and compositor
      advance_to(48);  chk("b_de48", b_o_de, 1);
                       chk("b_oh48", b_o_h, 0);
                       chk("b_ov48", b_o_v, 0);
      advance_to(49);  chk("b_vde49", b_vid_de, 0);
      advance_to(50);  chk("b_vde50", b_vid_de, 1);
                       chk("b_rgb50", b_vid_rgb, 8'h00);
      // layers 2,3 opaque in front, layer 1 clear, layer 0 opaque
      b_layer_rgb    = {8'h22, 8'h11, 8'h55, 8'h44};
      b_layer_valid  = 4'b1101;
      b_layer_behind = 4'b0000;
      advance_to(51);  chk("b_front_l2", b_vid_rgb, 8'h11);
      // only layer 1 opaque, drawn behind, layer 0 clear
      b_layer_valid  = 4'b0010;
      b_layer_behind = 4'b0010;
      advance_to(52);  chk("b_behind_l1", b_vid_rgb, 8'h55);
      b_layer_valid  = 4'b0011;
      advance_to(53);  chk("b_l0_over_behind", b_vid_rgb, 8'h44);
      b_layer_valid  = 4'b0111;
      advance_to(54);  chk("b_front_over_l0", b_vid_rgb, 8'h11);
      advance_to(55);  chk("b_oh55", b_o_h, 7);
      advance_to(58);  chk("a_hs58", a_vid_hs, 0);
      advance_to(59);  chk("a_hs59", a_vid_hs, 1);
      advance_to(62);  chk("b_ov62", b_o_v, 1);
                       chk("b_oh62", b_o_h, 0);
      advance_to(97);  chk("b_fc97", b_frame_count, 0);
      advance_to(98);  chk("b_fc98", b_frame_count, 1);
                       chk("b_irq98", b_frame_irq, 1);
                       chk("b_v98", b_v_count, 0);
      advance_to(99);  chk("b_irq99", b_frame_irq, 0);

      // dut_a vsync lag
      advance_to(1268); chk("a_vs1268", a_vid_vs, 1);
      advance_to(1269); chk("a_vs1269", a_vid_vs, 0);

      // dut_a first active pixel (h=102, v=22)
      advance_to(9385); chk("a_de9385", a_o_de, 0);
      advance_to(9386); chk("a_de9386", a_o_de, 1);
                        chk("a_h9386", a_h_count, 102);
                        chk("a_v9386", a_v_count, 22);
                        chk("a_oh9386", a_o_h, 0);
                        chk("a_ov9386", a_o_v, 0);
      advance_to(9388); chk("a_vde9388", a_vid_de, 0);
      advance_to(9389); chk("a_vde9389", a_vid_de, 1);

      // dut_a compositor
      advance_to(9500);
      a_layer_rgb    = {8'hE0, 8'h1C};
      a_layer_valid  = 2'b11;
      a_layer_behind = 2'b00;
      advance_to(9501); chk("a_l1_front", a_vid_rgb, 8'hE0);
      a_layer_behind = 2'b10;
      advance_to(9502); chk("a_l1_behind", a_vid_rgb, 8'h1C);
      a_layer_valid  = 2'b10;
      advance_to(9503); chk("a_l0_clear", a_vid_rgb, 8'hE0);
      a_layer_valid  = 2'b00;
      a_backdrop     = 8'h03;
      advance_to(9504); chk("a_backdrop", a_vid_rgb, 8'h03);

      // end of first active line
      advance_to(9705); chk("a_de9705", a_o_de, 1);
                        chk("a_oh9705", a_o_h, 319);
      advance_to(9706); chk("a_de9706", a_o_de, 0);
                        chk("a_oh9706", a_o_h, 0);
                        chk("a_h9706", a_h_count, 0);
                        chk("a_v9706", a_v_count, 23);
      advance_to(9708); chk("a_vde9708", a_vid_de, 1);
                        chk("a_rgb9708", a_vid_rgb, 8'h03);
      advance_to(9709); chk("a_vde9709", a_vid_de, 0);
                        chk("a_rgb_blank", a_vid_rgb, 8'h00);

      // mid-frame reset at v=100, inside the active area
      advance_to(42400); chk("a_h42400", a_h_count, 200);
                         chk("a_v42400", a_v_count, 100);
                         chk("a_vde42400", a_vid_de, 1);
                         chk("a_rgb42400", a_vid_rgb, 8'h03);
                         chk("b_fc42400", b_frame_count, 432);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cyc   = 0;
      chk("a_h_rst", a_h_count, 0);
      chk("a_v_rst", a_v_count, 0);
      chk("a_vde_rst", a_vid_de, 0);
      chk("a_rgb_rst", a_vid_rgb, 0);
      chk("a_fc_rst", a_frame_count, 0);
      chk("b_fc_rst", b_frame_count, 0);
      for (int k = 0; k < 3; k++) begin
         chk("a_hs_rst", a_vid_hs, 1);
         chk("a_vs_rst", a_vid_vs, 1);
         chk("a_vde_rst_hold", a_vid_de, 0);
         tick();
      end
      chk("a_h_after_rst", a_h_count, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
